// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive/transmit buffering path.
package uart_pkg;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 32;

  typedef struct packed {
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO core: array plus wrapping pointers and an occupancy count.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Flush wins over any push/pop in the same cycle.
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/axis_uart_rx_fifo.sv
// UART receive buffer: AXIS slave in, AXIS master out, with saturating drop and parity-error counters.
module axis_uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        saxis_tdata_i,
  input  logic                     saxis_tuser_i,
  input  logic                     saxis_tvalid_i,
  output logic                     saxis_tready_o,
  input  logic                     drop_i,
  output logic [DATA_W-1:0]        maxis_tdata_o,
  output logic                     maxis_tuser_o,
  output logic                     maxis_tvalid_o,
  input  logic                     maxis_tready_i,
  input  logic                     clear_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic [CNT_W-1:0]         perr_cnt_o
);
  logic             push, pop, full, empty;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] perr_cnt_q, perr_cnt_d;

  assign push = saxis_tvalid_i && saxis_tready_o;
  assign pop  = maxis_tvalid_o && maxis_tready_i;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({saxis_tuser_i, saxis_tdata_i}),
    .rdata_o ({maxis_tuser_o, maxis_tdata_o}),
    .full_o  (full),
    .empty_o (empty),
    .count_o (level_o)
  );

  // Handshake flags come straight off the registered count, so no input-to-output path exists.
  assign saxis_tready_o = !full;
  assign maxis_tvalid_o = !empty;

  always_comb begin
    drop_cnt_d = sat_inc(drop_cnt_q, drop_i);
    perr_cnt_d = sat_inc(perr_cnt_q, push && saxis_tuser_i);
    if (clear_i) begin
      drop_cnt_d = '0;
      perr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
      perr_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      perr_cnt_q <= perr_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign perr_cnt_o = perr_cnt_q;
endmodule

// File: tb/tb_axis_uart_rx_fifo.sv
// Bench for axis_uart_rx_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_axis_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam logic [31:0] MAX32 = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_tdata = '0;
  logic        s_tuser = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        drop = 1'b0;
  logic [7:0]  m_tdata;
  logic        m_tuser;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        clear = 1'b0;
  logic [4:0]  level;
  logic [31:0] drop_cnt, perr_cnt;

  int checks = 0;
  int errors = 0;

  logic [8:0]  mq[$];
  logic [8:0]  popped[$];
  logic [31:0] m_drop = '0;
  logic [31:0] m_perr = '0;
  logic        preset_perr = 1'b0;

  axis_uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .saxis_tdata_i  (s_tdata),
    .saxis_tuser_i  (s_tuser),
    .saxis_tvalid_i (s_tvalid),
    .saxis_tready_o (s_tready),
    .drop_i         (drop),
    .maxis_tdata_o  (m_tdata),
    .maxis_tuser_o  (m_tuser),
    .maxis_tvalid_o (m_tvalid),
    .maxis_tready_i (m_tready),
    .clear_i        (clear),
    .level_o        (level),
    .drop_cnt_o     (drop_cnt),
    .perr_cnt_o     (perr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus two saturating integers, updated from the edge's inputs.
  always @(posedge clk) begin
    logic do_push, do_pop;
    if (rst || clear) begin
      mq.delete();
      m_drop = '0;
      m_perr = '0;
    end else begin
      if (preset_perr) m_perr = MAX32;
      do_push = s_tvalid && (mq.size() != DEPTH);
      do_pop  = (mq.size() != 0) && m_tready;
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({s_tuser, s_tdata});
      if (drop && m_drop != MAX32) m_drop = m_drop + 1;
      if (do_push && s_tuser && m_perr != MAX32) m_perr = m_perr + 1;
    end
  end

  // Record what the DUT actually hands out, for the directed order checks.
  always @(posedge clk) begin
    if (!rst && !clear && m_tvalid && m_tready) popped.push_back({m_tuser, m_tdata});
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("tready", 64'(s_tready), 64'(mq.size() != DEPTH));
      chk("tvalid", 64'(m_tvalid), 64'(mq.size() != 0));
      chk("level", 64'(level), 64'(mq.size()));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("perr_cnt", 64'(perr_cnt), 64'(m_perr));
      if (mq.size() != 0) chk("head", 64'({m_tuser, m_tdata}), 64'(mq[0]));
    end
  end

  task automatic push_byte(input logic [7:0] d, input logic u);
    s_tdata  = d;
    s_tuser  = u;
    s_tvalid = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input int n);
    m_tready = 1'b1;
    repeat (n) @(negedge clk);
    m_tready = 1'b0;
  endtask

  initial begin
    logic [3:0] upat;
    upat = 4'b1101;

    // Reset then idle
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_tready", 64'(s_tready), 64'd1);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_perr", 64'(perr_cnt), 64'd0);

    // Ordered pass-through
    push_byte(8'hA5, 1'b0);
    push_byte(8'h3C, 1'b0);
    push_byte(8'hFF, 1'b0);
    chk("pt_level3", 64'(level), 64'd3);
    popped.delete();
    m_tready = 1'b1;
    @(negedge clk); chk("pt_level2", 64'(level), 64'd2);
    @(negedge clk); chk("pt_level1", 64'(level), 64'd1);
    @(negedge clk); chk("pt_level0", 64'(level), 64'd0);
    chk("pt_tvalid_low", 64'(m_tvalid), 64'd0);
    m_tready = 1'b0;
    chk("pt_count", 64'(popped.size()), 64'd3);
    chk("pt_b0", 64'(popped[0]), 64'h0A5);
    chk("pt_b1", 64'(popped[1]), 64'h03C);
    chk("pt_b2", 64'(popped[2]), 64'h0FF);

    // Full boundary
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
    chk("full_tready", 64'(s_tready), 64'd0);
    chk("full_level", 64'(level), 64'd16);
    s_tdata = 8'h10; s_tuser = 1'b0; s_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_hold_level", 64'(level), 64'd16);
    m_tready = 1'b1;
    @(negedge clk);
    m_tready = 1'b0;
    chk("full_tready_rise", 64'(s_tready), 64'd1);
    popped.delete();
    @(negedge clk);
    s_tvalid = 1'b0;
    chk("full_refill", 64'(level), 64'd16);
    drain(16);
    chk("full_drain_cnt", 64'(popped.size()), 64'd16);
    for (int i = 0; i < 16; i++) chk("full_drain", 64'(popped[i]), 64'(i + 1));

    // Simultaneous push/pop at level 5, wrapping the pointers
    for (int i = 0; i < 5; i++) push_byte(8'(8'h20 + i), 1'b0);
    popped.delete();
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_tdata = 8'(8'h40 + i);
      s_tuser = i[0];
      @(negedge clk);
      chk("stream_level", 64'(level), 64'd5);
    end
    s_tvalid = 1'b0;
    repeat (5) @(negedge clk);
    m_tready = 1'b0;
    chk("stream_cnt", 64'(popped.size()), 64'd105);
    for (int i = 0; i < 5; i++) chk("stream_pre", 64'(popped[i]), 64'(8'h20 + i));
    for (int i = 0; i < 100; i++)
      chk("stream_seq", 64'(popped[i + 5]), 64'({i[0], 8'(8'h40 + i)}));

    // Error counters
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h11 + i), upat[3 - i]);
    repeat (3) begin
      drop = 1'b1; @(negedge clk);
      drop = 1'b0; @(negedge clk);
    end
    chk("err_perr3", 64'(perr_cnt), 64'd3);
    chk("err_drop3", 64'(drop_cnt), 64'd3);
    popped.delete();
    drain(4);
    chk("err_pop_cnt", 64'(popped.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("err_tuser", 64'(popped[i][8]), 64'(upat[3 - i]));

    force dut.perr_cnt_q = MAX32;
    preset_perr = 1'b1;
    @(negedge clk);
    release dut.perr_cnt_q;
    preset_perr = 1'b0;
    push_byte(8'h99, 1'b1);
    chk("perr_sat", 64'(perr_cnt), 64'(MAX32));
    drain(2);

    // Flush priority at level 7
    for (int i = 0; i < 7; i++) push_byte(8'(8'h60 + i), 1'b1);
    chk("flush_pre_level", 64'(level), 64'd7);
    s_tdata = 8'h77; s_tuser = 1'b1; s_tvalid = 1'b1;
    m_tready = 1'b1; clear = 1'b1; drop = 1'b1;
    @(negedge clk);
    s_tvalid = 1'b0; m_tready = 1'b0; clear = 1'b0; drop = 1'b0;
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_tvalid", 64'(m_tvalid), 64'd0);
    chk("flush_drop", 64'(drop_cnt), 64'd0);
    chk("flush_perr", 64'(perr_cnt), 64'd0);
    push_byte(8'h5A, 1'b0);
    popped.delete();
    drain(3);
    chk("flush_after_cnt", 64'(popped.size()), 64'd1);
    chk("flush_after_byte", 64'(popped[0]), 64'h05A);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
